// File: rtl/dcache_ahb_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ahb_controller
// Purpose  : Data-cache line-transfer engine on the M port of the AHB arbiter.
//            Writes back a dirty 4-word victim line, then fills the missing
//            4-word line critical-word-first as a pipelined AHB-Lite master.
// Revision : 1.0  initial release
// ============================================================================
module dcache_ahb_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic         MissM,
  input  logic         DirtyM,
  input  logic [31:0]  FillAddr,
  input  logic [31:0]  WBAddr,
  input  logic [127:0] WBData,
  input  logic         HReadyM,
  input  logic [31:0]  HRData,
  output logic         HRequestM,
  output logic         HWriteM,
  output logic [2:0]   HSizeM,
  output logic [31:0]  HAddrM,
  output logic [31:0]  HWDataM,
  output logic         FillWE,
  output logic [1:0]   FillWordSel,
  output logic [31:0]  FillData,
  output logic         Busy,
  output logic         Done
);

  localparam logic [2:0] C_HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     ac_q, ac_d;          // address phases issued
  logic [2:0]     dc_q, dc_d;          // data phases completed
  logic           dpend_q, dpend_d;    // a data phase is outstanding
  logic [27:0]    fill_line_q, fill_line_d;
  logic [1:0]     crit_q, crit_d;
  logic [27:0]    wb_line_q, wb_line_d;
  logic [127:0]   wb_data_q, wb_data_d;

  logic           w_xfer;
  logic           w_addr_req;
  logic           w_addr_acc;
  logic           w_data_done;
  logic [1:0]     w_fill_idx_a;
  logic [1:0]     w_fill_idx_d;
  logic [31:0]    w_wb_word;
  logic           w_unused;

  // Word-offset and victim low bits are never used by a line transfer.
  assign w_unused = ^{FillAddr[1:0], WBAddr[3:0]};

  // Bus handshake qualifiers shared by the next-state and output logic.
  always_comb begin
    w_xfer       = (state_q == S_WB) || (state_q == S_FILL);
    w_addr_req   = w_xfer && !ac_q[2];
    w_addr_acc   = w_addr_req && HReadyM;
    w_data_done  = w_xfer && dpend_q && HReadyM;
    w_fill_idx_a = crit_q + ac_q[1:0];
    w_fill_idx_d = crit_q + dc_q[1:0];
    w_wb_word    = wb_data_q[{dc_q[1:0], 5'b00000} +: 32];
  end

  // State and counter register; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ac_q        <= 3'd0;
      dc_q        <= 3'd0;
      dpend_q     <= 1'b0;
      fill_line_q <= 28'd0;
      crit_q      <= 2'd0;
      wb_line_q   <= 28'd0;
      wb_data_q   <= 128'd0;
    end else begin
      state_q     <= state_d;
      ac_q        <= ac_d;
      dc_q        <= dc_d;
      dpend_q     <= dpend_d;
      fill_line_q <= fill_line_d;
      crit_q      <= crit_d;
      wb_line_q   <= wb_line_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // Next-state: capture on a miss, then advance address/data counters.
  always_comb begin
    state_d     = state_q;
    ac_d        = ac_q;
    dc_d        = dc_q;
    dpend_d     = dpend_q;
    fill_line_d = fill_line_q;
    crit_d      = crit_q;
    wb_line_d   = wb_line_q;
    wb_data_d   = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (MissM) begin
          fill_line_d = FillAddr[31:4];
          crit_d      = FillAddr[3:2];
          wb_line_d   = WBAddr[31:4];
          wb_data_d   = WBData;
          state_d     = DirtyM ? S_WB : S_FILL;
          ac_d        = 3'd0;
          dc_d        = 3'd0;
          dpend_d     = 1'b0;
        end
      end
      S_WB, S_FILL: begin
        if (w_addr_acc) begin
          ac_d = ac_q + 3'd1;
        end
        if (w_addr_acc) begin
          dpend_d = 1'b1;
        end else if (w_data_done) begin
          dpend_d = 1'b0;
        end
        if (w_data_done) begin
          dc_d = dc_q + 3'd1;
          // Last data phase of the line: the next phase starts clean, so the
          // first fill address never overlaps the last write data phase.
          if (dc_q == 3'd3) begin
            if (state_q == S_WB) begin
              state_d = S_FILL;
              ac_d    = 3'd0;
              dc_d    = 3'd0;
              dpend_d = 1'b0;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus and cache outputs, decoded from registered state plus HReadyM/HRData.
  always_comb begin
    HRequestM   = 1'b0;
    HWriteM     = 1'b0;
    HSizeM      = C_HSIZE_WORD;
    HAddrM      = 32'd0;
    HWDataM     = 32'd0;
    FillWE      = 1'b0;
    FillWordSel = 2'd0;
    FillData    = 32'd0;
    Busy        = (state_q != S_IDLE);
    Done        = (state_q == S_DONE);
    case (state_q)
      S_WB: begin
        HRequestM = w_addr_req;
        HWriteM   = 1'b1;
        HAddrM    = {wb_line_q, ac_q[1:0], 2'b00};
        HWDataM   = dpend_q ? w_wb_word : 32'd0;
      end
      S_FILL: begin
        HRequestM = w_addr_req;
        HAddrM    = {fill_line_q, w_fill_idx_a, 2'b00};
        if (w_data_done) begin
          FillWE      = 1'b1;
          FillWordSel = w_fill_idx_d;
          FillData    = HRData;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ahb_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ahb_controller
// Purpose  : Directed self-checking bench for dcache_ahb_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_dcache_ahb_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic         MissM;
  logic         DirtyM;
  logic [31:0]  FillAddr;
  logic [31:0]  WBAddr;
  logic [127:0] WBData;
  logic         HReadyM;
  logic [31:0]  HRData;
  logic         HRequestM;
  logic         HWriteM;
  logic [2:0]   HSizeM;
  logic [31:0]  HAddrM;
  logic [31:0]  HWDataM;
  logic         FillWE;
  logic [1:0]   FillWordSel;
  logic [31:0]  FillData;
  logic         Busy;
  logic         Done;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;

  always #5 clk = ~clk;

  dcache_ahb_controller dut (
    .clk         (clk),
    .reset       (reset),
    .MissM       (MissM),
    .DirtyM      (DirtyM),
    .FillAddr    (FillAddr),
    .WBAddr      (WBAddr),
    .WBData      (WBData),
    .HReadyM     (HReadyM),
    .HRData      (HRData),
    .HRequestM   (HRequestM),
    .HWriteM     (HWriteM),
    .HSizeM      (HSizeM),
    .HAddrM      (HAddrM),
    .HWDataM     (HWDataM),
    .FillWE      (FillWE),
    .FillWordSel (FillWordSel),
    .FillData    (FillData),
    .Busy        (Busy),
    .Done        (Done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs mid-cycle, then settle before sampling.
  task automatic cyc(input logic rdy, input logic miss);
    @(negedge clk);
    HReadyM = rdy;
    MissM   = miss;
    HRData  = 32'hDA7A_0000 + 32'(rd_cnt);
    rd_cnt++;
    #1;
  endtask

  task automatic exp_cyc(input string tag, input logic req, input logic wr,
                         input logic [31:0] addr, input logic chk_addr,
                         input logic [31:0] wd, input logic we, input logic [1:0] sel,
                         input logic busy, input logic done);
    chk({tag, ".req"},   32'(HRequestM),   32'(req));
    chk({tag, ".wr"},    32'(HWriteM),     32'(wr));
    chk({tag, ".size"},  32'(HSizeM),      32'd2);
    if (chk_addr) chk({tag, ".addr"}, HAddrM, addr);
    chk({tag, ".wdata"}, HWDataM,          wd);
    chk({tag, ".we"},    32'(FillWE),      32'(we));
    chk({tag, ".sel"},   32'(FillWordSel), 32'(sel));
    chk({tag, ".fdata"}, FillData,         we ? HRData : 32'd0);
    chk({tag, ".busy"},  32'(Busy),        32'(busy));
    chk({tag, ".done"},  32'(Done),        32'(done));
  endtask

  task automatic exp_idle(input string tag);
    exp_cyc(tag, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  // Present a miss so that the following rising edge is edge 0.
  task automatic start_miss(input logic dirty, input logic [31:0] fa,
                            input logic [31:0] wa, input logic [127:0] wd);
    @(negedge clk);
    MissM    = 1'b1;
    DirtyM   = dirty;
    FillAddr = fa;
    WBAddr   = wa;
    WBData   = wd;
    HReadyM  = 1'b1;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    MissM    = 1'b0;
    DirtyM   = 1'b0;
    FillAddr = 32'd0;
    WBAddr   = 32'd0;
    WBData   = 128'd0;
    HReadyM  = 1'b1;
    HRData   = 32'h1234_5678;
    #2;
    exp_idle("reset");
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 1'b0); exp_idle("idle0");

    // Clean miss, critical word 2: order 2,3,0,1
    start_miss(1'b0, 32'h0000_1238, 32'd0, 128'd0);
    cyc(1'b1, 1'b0); exp_cyc("t1c1", 1, 0, 32'h1238, 1, 0, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t1c2", 1, 0, 32'h123C, 1, 0, 1, 2'd2, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t1c3", 1, 0, 32'h1230, 1, 0, 1, 2'd3, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t1c4", 1, 0, 32'h1234, 1, 0, 1, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t1c5", 0, 0, 32'h0,    0, 0, 1, 2'd1, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t1c6", 0, 0, 32'h0,    1, 0, 0, 2'd0, 1, 1);
    cyc(1'b1, 1'b0); exp_idle("t1c7");

    // Dirty miss: write-back of A0..A3, then fill in order 0,1,2,3
    start_miss(1'b1, 32'h0000_2000, 32'h0000_4000,
               128'hA0A0_A003_A0A0_A002_A0A0_A001_A0A0_A000);
    cyc(1'b1, 1'b0);
    FillAddr = 32'hFFFF_FFFC;
    WBAddr   = 32'h0000_9990;
    WBData   = {4{32'hDEAD_BEEF}};
    DirtyM   = 1'b0;
    #1;
    exp_cyc("t2c1",  1, 1, 32'h4000, 1, 32'h0,         0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t2c2",  1, 1, 32'h4004, 1, 32'hA0A0_A000, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t2c3",  1, 1, 32'h4008, 1, 32'hA0A0_A001, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t2c4",  1, 1, 32'h400C, 1, 32'hA0A0_A002, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t2c5",  0, 1, 32'h0,    0, 32'hA0A0_A003, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t2c6",  1, 0, 32'h2000, 1, 32'h0,         0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t2c7",  1, 0, 32'h2004, 1, 32'h0,         1, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t2c8",  1, 0, 32'h2008, 1, 32'h0,         1, 2'd1, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t2c9",  1, 0, 32'h200C, 1, 32'h0,         1, 2'd2, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t2c10", 0, 0, 32'h0,    0, 32'h0,         1, 2'd3, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t2c11", 0, 0, 32'h0,    1, 32'h0,         0, 2'd0, 1, 1);
    cyc(1'b1, 1'b0); exp_idle("t2c12");

    // Clean miss, critical word 1, HReadyM low for 3 cycles in second data phase
    start_miss(1'b0, 32'h0000_3004, 32'd0, 128'd0);
    cyc(1'b1, 1'b0); exp_cyc("t3c1",  1, 0, 32'h3004, 1, 0, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t3c2",  1, 0, 32'h3008, 1, 0, 1, 2'd1, 1, 0);
    cyc(1'b0, 1'b0); exp_cyc("t3c3",  1, 0, 32'h300C, 1, 0, 0, 2'd0, 1, 0);
    cyc(1'b0, 1'b0); exp_cyc("t3c4",  1, 0, 32'h300C, 1, 0, 0, 2'd0, 1, 0);
    cyc(1'b0, 1'b0); exp_cyc("t3c5",  1, 0, 32'h300C, 1, 0, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t3c6",  1, 0, 32'h300C, 1, 0, 1, 2'd2, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t3c7",  1, 0, 32'h3000, 1, 0, 1, 2'd3, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t3c8",  0, 0, 32'h0,    0, 0, 1, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t3c9",  0, 0, 32'h0,    1, 0, 0, 2'd0, 1, 1);
    cyc(1'b1, 1'b0); exp_idle("t3c10");

    // MissM held through Done; FillAddr changed mid-transfer
    start_miss(1'b0, 32'h0000_5000, 32'd0, 128'd0);
    cyc(1'b1, 1'b1); exp_cyc("t4c1",  1, 0, 32'h5000, 1, 0, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b1); exp_cyc("t4c2",  1, 0, 32'h5004, 1, 0, 1, 2'd0, 1, 0);
    FillAddr = 32'h0000_6008;
    cyc(1'b1, 1'b1); exp_cyc("t4c3",  1, 0, 32'h5008, 1, 0, 1, 2'd1, 1, 0);
    cyc(1'b1, 1'b1); exp_cyc("t4c4",  1, 0, 32'h500C, 1, 0, 1, 2'd2, 1, 0);
    cyc(1'b1, 1'b1); exp_cyc("t4c5",  0, 0, 32'h0,    0, 0, 1, 2'd3, 1, 0);
    cyc(1'b1, 1'b1); exp_cyc("t4c6",  0, 0, 32'h0,    1, 0, 0, 2'd0, 1, 1);
    cyc(1'b1, 1'b1); exp_idle("t4c7");
    cyc(1'b1, 1'b0); exp_cyc("t4c8",  1, 0, 32'h6008, 1, 0, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t4c9",  1, 0, 32'h600C, 1, 0, 1, 2'd2, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t4c10", 1, 0, 32'h6000, 1, 0, 1, 2'd3, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t4c11", 1, 0, 32'h6004, 1, 0, 1, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t4c12", 0, 0, 32'h0,    0, 0, 1, 2'd1, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t4c13", 0, 0, 32'h0,    1, 0, 0, 2'd0, 1, 1);
    cyc(1'b1, 1'b0); exp_idle("t4c14");

    // Asynchronous reset during the third write-back address
    start_miss(1'b1, 32'h0000_700C, 32'h0000_8000,
               128'hB0B0_B003_B0B0_B002_B0B0_B001_B0B0_B000);
    cyc(1'b1, 1'b0); exp_cyc("t5c1", 1, 1, 32'h8000, 1, 32'h0,         0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t5c2", 1, 1, 32'h8004, 1, 32'hB0B0_B000, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t5c3", 1, 1, 32'h8008, 1, 32'hB0B0_B001, 0, 2'd0, 1, 0);
    reset = 1'b1;
    #1;
    exp_idle("t5rst");
    #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0); exp_idle("t5post1");
    cyc(1'b1, 1'b0); exp_idle("t5post2");
    cyc(1'b1, 1'b0); exp_idle("t5post3");

    // Fresh clean miss after reset, critical word 3: order 3,0,1,2
    start_miss(1'b0, 32'h0000_700C, 32'd0, 128'd0);
    cyc(1'b1, 1'b0); exp_cyc("t6c1", 1, 0, 32'h700C, 1, 0, 0, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t6c2", 1, 0, 32'h7000, 1, 0, 1, 2'd3, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t6c3", 1, 0, 32'h7004, 1, 0, 1, 2'd0, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t6c4", 1, 0, 32'h7008, 1, 0, 1, 2'd1, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t6c5", 0, 0, 32'h0,    0, 0, 1, 2'd2, 1, 0);
    cyc(1'b1, 1'b0); exp_cyc("t6c6", 0, 0, 32'h0,    1, 0, 0, 2'd0, 1, 1);
    cyc(1'b1, 1'b0); exp_idle("t6c7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
